// File: rtl/maquina_chocolate_param.sv
// Vending controller: debounced coin/cancel inputs, credit accumulator, timed vend,
// coin-by-coin change return and inactivity refund, all on the board clock.
module maquina_chocolate_param #(
  parameter int PRICE      = 5,
  parameter int CREDIT_W   = 6,
  parameter int DEB_CYC    = 250000,
  parameter int TICK_DIV   = 12500000,
  parameter int VEND_TICKS = 4,
  parameter int TOUT_TICKS = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                nc20,
  input  logic                nc10,
  input  logic                nc5,
  input  logic                ncancel,
  output logic                vend,
  output logic                change5,
  output logic                reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [3:0]          led
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int VW = $clog2(VEND_TICKS + 1);
  localparam int OW = $clog2(TOUT_TICKS + 1);
  localparam int SW = CREDIT_W + 3;

  localparam logic [DW-1:0]       DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [VW-1:0]       VEND_LAST = VW'(VEND_TICKS - 1);
  localparam logic [OW-1:0]       TOUT_LAST = OW'(TOUT_TICKS - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [SW-1:0]       CREDIT_MAX = {3'b000, {CREDIT_W{1'b1}}};

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_VEND    = 2'd1,
    S_RETURN  = 2'd2
  } state_t;

  // Input bit order everywhere: [3] coin 20, [2] coin 10, [1] coin 5, [0] cancel.
  logic [3:0]    sync1, sync2, armed, evt;
  logic [DW-1:0] deb_cnt [4];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 4'hf;
      sync2 <= 4'hf;
      armed <= 4'hf;
      evt   <= 4'h0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= {nc20, nc10, nc5, ncancel};
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        evt[i] <= 1'b0;
        // Armed: count a stable low press. Disarmed: count a stable high release.
        if (armed[i] ? !sync2[i] : sync2[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb_cnt[i] <= '0;
            armed[i]   <= !armed[i];
            evt[i]     <= armed[i];
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Coin values 4/2/1 line up with the event bits, so the sum is just the bits.
  logic [2:0] coin_sum;
  logic       coin_any;
  logic       cancel_evt;
  assign coin_sum   = evt[3:1];
  assign coin_any   = |evt[3:1];
  assign cancel_evt = evt[0];

  state_t        state, state_n;
  logic [TW-1:0] div_cnt;
  logic [VW-1:0] vt_cnt, vt_n;
  logic [OW-1:0] tout_cnt, tout_n;
  logic [CREDIT_W-1:0] credit_n;
  logic          tick, div_clr;
  logic          vend_c, change_c, reject_c;
  logic [SW-1:0] sum_w;
  logic          fits;

  assign tick  = (div_cnt == TICK_LAST);
  assign sum_w = {3'b000, credit} + SW'(coin_sum);
  assign fits  = (sum_w <= CREDIT_MAX);

  always_comb begin
    state_n  = state;
    credit_n = credit;
    vt_n     = vt_cnt;
    tout_n   = tout_cnt;
    div_clr  = 1'b0;
    vend_c   = 1'b0;
    change_c = 1'b0;
    reject_c = 1'b0;
    case (state)
      S_COLLECT: begin
        if (credit >= PRICE_C) begin
          state_n  = S_VEND;
          credit_n = credit - PRICE_C;
          div_clr  = 1'b1;
          vt_n     = '0;
          tout_n   = '0;
          reject_c = coin_any;
        end else begin
          if (coin_any) begin
            if (fits) begin
              credit_n = sum_w[CREDIT_W-1:0];
              tout_n   = '0;
            end else begin
              reject_c = 1'b1;
            end
          end
          if (cancel_evt && credit != '0) begin
            state_n = S_RETURN;
            tout_n  = '0;
          end else if (tick && credit != '0 && !(coin_any && fits)) begin
            if (tout_cnt == TOUT_LAST) begin
              state_n = S_RETURN;
              tout_n  = '0;
            end else begin
              tout_n = tout_cnt + 1'b1;
            end
          end
        end
      end
      S_VEND: begin
        vend_c   = 1'b1;
        reject_c = coin_any;
        if (tick) begin
          if (vt_cnt == VEND_LAST) begin
            vt_n    = '0;
            state_n = (credit != '0) ? S_RETURN : S_COLLECT;
          end else begin
            vt_n = vt_cnt + 1'b1;
          end
        end
      end
      S_RETURN: begin
        reject_c = coin_any;
        if (credit == '0) begin
          state_n = S_COLLECT;
        end else if (tick) begin
          change_c = 1'b1;
          credit_n = credit - 1'b1;
          if (credit == CREDIT_W'(1)) state_n = S_COLLECT;
        end
      end
      default: state_n = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_COLLECT;
      credit   <= '0;
      div_cnt  <= '0;
      vt_cnt   <= '0;
      tout_cnt <= '0;
      led      <= 4'b0001;
    end else begin
      state    <= state_n;
      credit   <= credit_n;
      vt_cnt   <= vt_n;
      tout_cnt <= tout_n;
      div_cnt  <= (div_clr || tick) ? '0 : div_cnt + 1'b1;
      led      <= {credit != '0, state == S_RETURN, state == S_VEND, state == S_COLLECT};
    end
  end

  assign vend    = vend_c;
  assign change5 = change_c;
  assign reject  = reject_c;

endmodule

// File: tb/tb_maquina_chocolate_param.sv
// Bench for the vending controller with short debounce/tick parameters:
// table of single presses from reset, then hand-written multi-cycle sequences.
module tb_maquina_chocolate_param;

  logic       clk = 1'b0;
  logic       rst, nc20, nc10, nc5, ncancel;
  logic       vend, change5, reject;
  logic [5:0] credit;
  logic [3:0] led;

  maquina_chocolate_param #(
    .PRICE(5), .CREDIT_W(6), .DEB_CYC(4), .TICK_DIV(8), .VEND_TICKS(2), .TOUT_TICKS(5)
  ) dut (
    .clk(clk), .rst(rst), .nc20(nc20), .nc10(nc10), .nc5(nc5), .ncancel(ncancel),
    .vend(vend), .change5(change5), .reject(reject), .credit(credit), .led(led)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: observed credit changes vs expected queue, plus pulse counters.
  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];
  logic [5:0] prev_c;
  int chg_cnt, rej_cnt, vend_cyc, gap_bad, last_chg;
  int cyc = 0;
  int clr_req = 0;
  int clr_ack = 0;

  always @(negedge clk) begin
    cyc++;
    if (clr_req != clr_ack) begin
      clr_ack = clr_req;
      obs_q.delete();
      prev_c = credit;
      chg_cnt = 0; rej_cnt = 0; vend_cyc = 0; gap_bad = 0; last_chg = -1;
    end else begin
      if (credit != prev_c) begin
        obs_q.push_back(credit);
        prev_c = credit;
      end
      if (change5) begin
        if (last_chg >= 0 && cyc - last_chg != 8) gap_bad++;
        last_chg = cyc;
        chg_cnt++;
      end
      if (reject) rej_cnt++;
      if (vend) vend_cyc++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr_req++;
    @(negedge clk);
    #1;
    step(1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    {nc20, nc10, nc5, ncancel} = 4'hf;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  // mask bits: [3] coin 20, [2] coin 10, [1] coin 5, [0] cancel
  task automatic press(input logic [3:0] mask, input int hold);
    {nc20, nc10, nc5, ncancel} = ~mask;
    step(hold);
    {nc20, nc10, nc5, ncancel} = 4'hf;
    step(10);
  endtask

  task automatic wait_idle(input string name);
    int found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      @(negedge clk);
      if (led == 4'b0001) found = 1;
    end
    check({name, " idle_reached"}, found, 1);
    step(1);
  endtask

  task automatic check_q(input string name);
    check({name, " n_credit_steps"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s credit_step%0d", name, i), obs_q[i], exp_q[i]);
  endtask

  typedef struct {
    logic [3:0] mask;
    int         hold;
    int         exp_first;
    int         exp_rej;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{4'b1000, 8, 4, 0};
    vecs[1] = '{4'b0100, 8, 2, 0};
    vecs[2] = '{4'b0010, 8, 1, 0};
    vecs[3] = '{4'b0010, 3, 0, 0};
    vecs[4] = '{4'b1100, 8, 6, 0};
    vecs[5] = '{4'b1110, 8, 7, 0};
    vecs[6] = '{4'b0001, 8, 0, 0};

    rst = 1'b0;
    {nc20, nc10, nc5, ncancel} = 4'hf;
    do_reset();
    check("reset credit", credit, 0);
    check("reset led", led, 4'b0001);
    check("reset vend", vend, 0);
    check("reset change5", change5, 0);
    check("reset reject", reject, 0);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      clear_mon();
      press(vecs[v].mask, vecs[v].hold);
      check($sformatf("vec%0d first_credit", v), (obs_q.size() > 0) ? int'(obs_q[0]) : 0,
            vecs[v].exp_first);
      check($sformatf("vec%0d rejects", v), rej_cnt, vecs[v].exp_rej);
    end
    check("cancel_at_zero led", led, 4'b0001);

    // 20 + 5: exact price, vend without change
    do_reset(); clear_mon();
    press(4'b1000, 8); press(4'b0010, 8);
    wait_idle("exact");
    exp_q = '{6'd4, 6'd5, 6'd0};
    check_q("exact");
    check("exact vend_cycles", vend_cyc, 16);
    check("exact change5", chg_cnt, 0);
    check("exact led", led, 4'b0001);

    // 20 + 20: vend then three change pulses one tick apart
    do_reset(); clear_mon();
    press(4'b1000, 8); press(4'b1000, 8);
    wait_idle("change");
    exp_q = '{6'd4, 6'd8, 6'd3, 6'd2, 6'd1, 6'd0};
    check_q("change");
    check("change vend_cycles", vend_cyc, 16);
    check("change change5", chg_cnt, 3);
    check("change pulse_spacing_errs", gap_bad, 0);
    check("change credit_end", credit, 0);

    // 10 then cancel
    do_reset(); clear_mon();
    press(4'b0100, 8); press(4'b0001, 8);
    wait_idle("cancel");
    exp_q = '{6'd2, 6'd1, 6'd0};
    check_q("cancel");
    check("cancel change5", chg_cnt, 2);
    check("cancel vend_cycles", vend_cyc, 0);

    // 5 then idle: inactivity refund
    do_reset(); clear_mon();
    press(4'b0010, 8);
    check("timeout credit_before", credit, 1);
    wait_idle("timeout");
    exp_q = '{6'd1, 6'd0};
    check_q("timeout");
    check("timeout change5", chg_cnt, 1);

    // bouncing coin-5: low 5, high 1, low 5 counts once
    do_reset(); clear_mon();
    nc5 = 1'b0; step(5); nc5 = 1'b1; step(1); nc5 = 1'b0; step(5); nc5 = 1'b1; step(10);
    check("bounce credit", credit, 1);
    wait_idle("bounce");
    exp_q = '{6'd1, 6'd0};
    check_q("bounce");

    // coin 10 arriving during VEND is rejected
    do_reset(); clear_mon();
    press(4'b1000, 8);
    nc5 = 1'b0; step(8);
    nc5 = 1'b1; nc10 = 1'b0; step(8);
    nc10 = 1'b1; step(10);
    wait_idle("vend_coin");
    exp_q = '{6'd4, 6'd5, 6'd0};
    check_q("vend_coin");
    check("vend_coin rejects", rej_cnt, 1);
    check("vend_coin vend_cycles", vend_cyc, 16);
    check("vend_coin change5", chg_cnt, 0);

    // reset in the middle of VEND loses credit and issues no change
    do_reset(); clear_mon();
    press(4'b1000, 8); press(4'b1000, 8);
    check("midreset vend_before", vend, 1);
    check("midreset credit_before", credit, 3);
    do_reset(); clear_mon();
    step(40);
    check("midreset change5", chg_cnt, 0);
    check("midreset credit", credit, 0);
    check("midreset vend", vend, 0);
    check("midreset led", led, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
